pc_next_gen: RTL and testbench
==============================

PC_NEXT_GEN -- requirements
Module: pc_next_gen

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset, takes effect immediately, no clock needed).
REQ-003 SHALL have port stallF, input, 1, fetch stall; 1 means pcF must hold.
REQ-004 SHALL have ports branchD, pred_takeD, input, 1 each, the D-stage branch flag and predicted-taken flag from the branch predictor.
REQ-005 SHALL have ports pcD, immD, input, 32 each, the D-stage PC and sign-extended 16-bit immediate.
REQ-006 SHALL have ports branchM, pred_takeM, actual_takeM, input, 1 each, the resolved-branch flag, prediction carried down and actual outcome at M.
REQ-007 SHALL have ports pcM, branch_targetM, input, 32 each, the M-stage branch PC and computed target.
REQ-008 SHALL have ports except_flush, input, 1, and except_pc, input, 32, the exception redirect request and handler address.
REQ-009 SHALL have port pcF, output, 32, the current fetch PC.
REQ-010 SHALL have port inst_req, output, 1, the fetch-request valid to the instruction interface.
REQ-011 SHALL have port mispredictM, output, 1, the M-stage misprediction flag; it is combinational.
REQ-012 SHALL have port flush_req, output, 1, the flush request to F/D/E (mispredictM | except_flush); it is combinational.

Function
REQ-013 SHALL compute pred_targetD = pcD + 4 + (immD << 2), with 32-bit wrap-around and carry discarded.
REQ-014 SHALL set mispredictM = branchM & (pred_takeM ^ actual_takeM).
REQ-015 SHALL set correct_pc = branch_targetM when actual_takeM = 1, else pcM + 8 (the delay slot has already been fetched).
REQ-016 SHALL select the redirect source with fixed priority: except_flush > mispredictM > (branchD & pred_takeD) > pcF + 4.
REQ-017 SHALL contain FSM states BOOT, RUN and HOLD.
REQ-018 BOOT: entered on reset; inst_req = 0; SHALL go to RUN on the first clock edge after rst = 1.
REQ-019 RUN: inst_req = 1.
REQ-020 RUN, stallF = 0: pcF SHALL load the selected next PC on the edge.
REQ-021 RUN, stallF = 1 with any redirect present: SHALL latch it into pending_pc/pending_prio and go to HOLD; pcF holds.
REQ-022 RUN, stallF = 1 with no redirect: SHALL stay in RUN; pcF holds.
REQ-023 HOLD: inst_req = 1; pcF holds while stallF = 1.
REQ-024 HOLD, new redirect arriving: SHALL overwrite the pending entry only if its priority is greater than or equal to pending_prio; a lower-priority request is dropped.
REQ-025 HOLD, stallF = 0: pcF SHALL load either a same-cycle redirect that outranks the pending entry (priority at least pending_prio) or pending_pc, then clear the pending entry and go to RUN.
REQ-026 The sequential PC (pcF + 4) SHALL never be latched as pending.
REQ-027 except_flush SHALL redirect regardless of branch inputs; if asserted at the same time as mispredictM, except_pc wins.
REQ-028 branchD & pred_takeD in the same cycle as mispredictM SHALL be ignored, because the D instruction is on the wrong path.
REQ-029 pcF SHALL change only on a clock edge with stallF = 0, or on reset.

Reset
REQ-030 On rst = 0: pcF = 32'hBFC0_0000, state = BOOT, inst_req = 0, pending entry cleared.
REQ-031 With rst = 0, mispredictM and flush_req SHALL still follow their combinational equations (REQ-011, REQ-012).
REQ-032 Reset asserted mid-HOLD SHALL discard the pending redirect immediately, without waiting for a clock edge.
REQ-033 After rst rises, the first request SHALL be inst_req = 1 with pcF = 32'hBFC0_0000 one cycle later.

Verification
REQ-034 Release reset, no stalls, no branches -> inst_req rises after 1 cycle; pcF sequence BFC00000, BFC00004, BFC00008.
REQ-035 branchD=1, pred_takeD=1, pcD=BFC00010, immD=FFFFFFFC -> next pcF = BFC00004.
REQ-036 branchM=1, pred_takeM=1, actual_takeM=0, pcM=BFC00020 -> mispredictM=1, flush_req=1, next pcF = BFC00028.
REQ-037 stallF=1 for 3 cycles; cycle 1 mispredict to 80001000, cycle 2 except_flush with except_pc=BFC00380 -> pcF holds; after stallF falls, pcF = BFC00380.
REQ-038 except_flush and mispredictM in the same cycle with stallF=0 -> pcF = except_pc.
REQ-039 Assert rst in HOLD with a pending redirect, then release -> pcF = BFC00000 and the old pending target is never issued.

Source files
------------

// File: rtl/pc_next_gen.sv
// Next-fetch-PC generator: picks the next fetch address from exception,
// branch misprediction, predicted-taken D-stage branch or sequential PC,
// and buffers the highest-priority redirect while fetch is stalled.
module pc_next_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallF,
    input  logic        branchD,
    input  logic        pred_takeD,
    input  logic [31:0] pcD,
    input  logic [31:0] immD,
    input  logic        branchM,
    input  logic        pred_takeM,
    input  logic        actual_takeM,
    input  logic [31:0] pcM,
    input  logic [31:0] branch_targetM,
    input  logic        except_flush,
    input  logic [31:0] except_pc,
    output logic [31:0] pcF,
    output logic        inst_req,
    output logic        mispredictM,
    output logic        flush_req
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC  = 32'hBFC0_0000;

    // Redirect priorities; a larger value outranks a smaller one.
    localparam logic [1:0]  PRIO_NONE = 2'd0;
    localparam logic [1:0]  PRIO_BRD  = 2'd1;
    localparam logic [1:0]  PRIO_MIS  = 2'd2;
    localparam logic [1:0]  PRIO_EXC  = 2'd3;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_pcF;
    logic [31:0] w_nextPc;
    logic [31:0] r_pendingPc;
    logic [31:0] w_nextPendingPc;
    logic [1:0]  r_pendingPrio;
    logic [1:0]  w_nextPendingPrio;

    logic [31:0] w_seqPc;
    logic [31:0] w_predTargetD;
    logic [31:0] w_correctPc;
    logic        w_mispredict;
    logic        w_predTakenD;
    logic [31:0] w_redirPc;
    logic [1:0]  w_redirPrio;
    logic        w_redirValid;
    logic        w_redirOutranks;

    assign w_seqPc       = r_pcF + 32'd4;
    assign w_predTargetD = pcD + 32'd4 + {immD[29:0], 2'b00};
    // The delay slot is already fetched, so the not-taken path resumes at pcM + 8.
    assign w_correctPc   = actual_takeM ? branch_targetM : (pcM + 32'd8);
    assign w_mispredict  = branchM & (pred_takeM ^ actual_takeM);
    // A D-stage prediction is on the wrong path when M mispredicts; it is ignored then.
    assign w_predTakenD  = branchD & pred_takeD & ~w_mispredict;

    assign mispredictM   = w_mispredict;
    assign flush_req     = w_mispredict | except_flush;
    assign pcF           = r_pcF;

    // Fixed-priority redirect select; the sequential PC is the fallback and never counts as a redirect.
    always_comb begin
        w_redirPc   = w_seqPc;
        w_redirPrio = PRIO_NONE;
        if (except_flush) begin
            w_redirPc   = except_pc;
            w_redirPrio = PRIO_EXC;
        end else if (w_mispredict) begin
            w_redirPc   = w_correctPc;
            w_redirPrio = PRIO_MIS;
        end else if (w_predTakenD) begin
            w_redirPc   = w_predTargetD;
            w_redirPrio = PRIO_BRD;
        end
    end

    assign w_redirValid    = (w_redirPrio != PRIO_NONE);
    assign w_redirOutranks = w_redirValid && (w_redirPrio >= r_pendingPrio);

    // Next-state, next-PC and pending-entry logic for the BOOT/RUN/HOLD machine.
    always_comb begin
        w_nextState       = r_state;
        w_nextPc          = r_pcF;
        w_nextPendingPc   = r_pendingPc;
        w_nextPendingPrio = r_pendingPrio;
        inst_req          = 1'b0;
        case (r_state)
            BOOT: begin
                w_nextState = RUN;
            end
            RUN: begin
                inst_req = 1'b1;
                if (!stallF) begin
                    w_nextPc = w_redirPc;
                end else if (w_redirValid) begin
                    w_nextPendingPc   = w_redirPc;
                    w_nextPendingPrio = w_redirPrio;
                    w_nextState       = HOLD;
                end
            end
            HOLD: begin
                inst_req = 1'b1;
                if (stallF) begin
                    if (w_redirOutranks) begin
                        w_nextPendingPc   = w_redirPc;
                        w_nextPendingPrio = w_redirPrio;
                    end
                end else begin
                    w_nextPc          = w_redirOutranks ? w_redirPc : r_pendingPc;
                    w_nextPendingPc   = 32'd0;
                    w_nextPendingPrio = PRIO_NONE;
                    w_nextState       = RUN;
                end
            end
            default: begin
                w_nextState = BOOT;
            end
        endcase
    end

    // State register; reset returns to BOOT immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= BOOT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Fetch PC and pending-redirect registers; reset drops any pending redirect at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcF         <= RESET_PC;
            r_pendingPc   <= 32'd0;
            r_pendingPrio <= PRIO_NONE;
        end else begin
            r_pcF         <= w_nextPc;
            r_pendingPc   <= w_nextPendingPc;
            r_pendingPrio <= w_nextPendingPrio;
        end
    end

endmodule

// File: tb/tb_pc_next_gen.sv
// Scoreboard bench for pc_next_gen: a driver applies one directed vector per
// cycle and queues the outputs expected in that cycle; a monitor pops and
// compares them on the falling edge.
module tb_pc_next_gen;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        branchD;
    logic        pred_takeD;
    logic [31:0] pcD;
    logic [31:0] immD;
    logic        branchM;
    logic        pred_takeM;
    logic        actual_takeM;
    logic [31:0] pcM;
    logic [31:0] branch_targetM;
    logic        except_flush;
    logic [31:0] except_pc;
    logic [31:0] pcF;
    logic        inst_req;
    logic        mispredictM;
    logic        flush_req;

    typedef struct {
        int          idx;
        logic        req;
        logic [31:0] pc;
        logic        mis;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   compared = 0;
    int   mismatched = 0;
    int   vecIdx = 0;

    pc_next_gen dut (
        .clk            (clk),
        .rst            (rst),
        .stallF         (stallF),
        .branchD        (branchD),
        .pred_takeD     (pred_takeD),
        .pcD            (pcD),
        .immD           (immD),
        .branchM        (branchM),
        .pred_takeM     (pred_takeM),
        .actual_takeM   (actual_takeM),
        .pcM            (pcM),
        .branch_targetM (branch_targetM),
        .except_flush   (except_flush),
        .except_pc      (except_pc),
        .pcF            (pcF),
        .inst_req       (inst_req),
        .mispredictM    (mispredictM),
        .flush_req      (flush_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    // Waits past the next rising edge, drives this cycle's inputs and queues
    // the outputs expected to be visible for the rest of the cycle.
    task automatic applyStimulus(
        input logic r, input logic st,
        input logic bD, input logic ptD, input logic [31:0] pD, input logic [31:0] iD,
        input logic bM, input logic ptM, input logic atM, input logic [31:0] pM, input logic [31:0] tM,
        input logic ef, input logic [31:0] ep,
        input logic eReq, input logic [31:0] ePc, input logic eMis, input logic eFlush);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; stallF = st;
        branchD = bD; pred_takeD = ptD; pcD = pD; immD = iD;
        branchM = bM; pred_takeM = ptM; actual_takeM = atM; pcM = pM; branch_targetM = tM;
        except_flush = ef; except_pc = ep;
        e.idx = vecIdx; e.req = eReq; e.pc = ePc; e.mis = eMis; e.flush = eFlush;
        sb.push_back(e);
        vecIdx++;
    endtask

    task automatic idle(input logic st, input logic eReq, input logic [31:0] ePc);
        applyStimulus(1, st, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eReq, ePc, 0, 0);
    endtask

    // Monitor: compare the queued expectation against the DUT mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checkOutput($sformatf("c%0d inst_req", e.idx), {31'd0, inst_req}, {31'd0, e.req});
            checkOutput($sformatf("c%0d pcF", e.idx), pcF, e.pc);
            checkOutput($sformatf("c%0d mispredictM", e.idx), {31'd0, mispredictM}, {31'd0, e.mis});
            checkOutput($sformatf("c%0d flush_req", e.idx), {31'd0, flush_req}, {31'd0, e.flush});
        end
    end

    initial begin
        rst = 0; stallF = 0;
        branchD = 0; pred_takeD = 0; pcD = 0; immD = 0;
        branchM = 0; pred_takeM = 0; actual_takeM = 0; pcM = 0; branch_targetM = 0;
        except_flush = 0; except_pc = 0;

        // c0: in reset, combinational misprediction/flush still follow inputs
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0100, 0, 0, 0, 0, 32'hBFC0_0000, 1, 1);
        // c1: reset released, still BOOT
        idle(0, 0, 32'hBFC0_0000);
        // c2-c3: sequential fetch
        idle(0, 1, 32'hBFC0_0000);
        idle(0, 1, 32'hBFC0_0004);
        // c4: predicted-taken D branch, target BFC00010+4-16 = BFC00004
        applyStimulus(1, 0, 1, 1, 32'hBFC0_0010, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0008, 0, 0);
        // c5: mispredict not-taken at BFC00020 -> BFC00028
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'hBFC0_0020, 32'h1234_5678, 0, 0, 1, 32'hBFC0_0004, 1, 1);
        // c6: mispredict taken with same-cycle D prediction (ignored) -> 80000100
        applyStimulus(1, 0, 1, 1, 32'h0000_0000, 32'h0000_0000, 1, 0, 1, 32'h0000_0040, 32'h8000_0100, 0, 0, 1, 32'hBFC0_0028, 1, 1);
        idle(0, 1, 32'h8000_0100);
        // c8: correctly predicted branch at M, no redirect
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 1, 32'h8000_0000, 32'h9000_0000, 0, 0, 1, 32'h8000_0104, 0, 0);
        // c9-c12: stalled mispredict then stalled exception; exception wins
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h8000_0000, 32'h8000_1000, 0, 0, 1, 32'h8000_0108, 1, 1);
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0380, 1, 32'h8000_0108, 0, 1);
        idle(1, 1, 32'h8000_0108);
        idle(0, 1, 32'h8000_0108);
        idle(0, 1, 32'hBFC0_0380);
        // c14-c16: pending exception, lower-priority requests dropped
        applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0180, 1, 32'hBFC0_0384, 0, 1);
        applyStimulus(1, 1, 1, 1, 32'h0000_1000, 32'h0000_0004, 0, 0, 0, 0, 0, 0, 0, 1, 32'hBFC0_0384, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h4000_0000, 0, 0, 0, 1, 32'hBFC0_0384, 1, 1);
        idle(0, 1, 32'h8000_0180);
        // c18-c19: pending D prediction, equal-priority same-cycle request wins on release
        applyStimulus(1, 1, 1, 1, 32'h0000_2000, 32'h0000_0000, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0184, 0, 0);
        applyStimulus(1, 0, 1, 1, 32'h0000_3000, 32'h0000_0001, 0, 0, 0, 0, 0, 0, 0, 1, 32'h8000_0184, 0, 0);
        idle(0, 1, 32'h0000_3008);
        // c21: exception and mispredict together -> except_pc
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 32'h0000_0100, 0, 1, 32'hBFC0_0200, 1, 32'h0000_300C, 1, 1);
        idle(0, 1, 32'hBFC0_0200);
        // c23-c25: stall with no redirect simply holds
        idle(1, 1, 32'hBFC0_0204);
        idle(0, 1, 32'hBFC0_0204);
        idle(0, 1, 32'hBFC0_0208);
        // c26-c30: reset in HOLD discards the pending target immediately
        applyStimulus(1, 1, 0, 0, 0, 0, 1, 0, 1, 32'h0000_0200, 32'hDEAD_0000, 0, 0, 1, 32'hBFC0_020C, 1, 1);
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC0_0000, 0, 0);
        idle(0, 0, 32'hBFC0_0000);
        idle(0, 1, 32'hBFC0_0000);
        idle(0, 1, 32'hBFC0_0004);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
